// File: rtl/ysyx_22040632_div_pkg.sv
// rtl/ysyx_22040632_div_pkg.sv - shared types and constants for the sequential divider
// Contents: FSM state enum, operating-width constants, special-case code enum.
package ysyx_22040632_div_pkg;

  localparam int W32 = 32;
  localparam int W64 = 64;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    NONE,
    DIVZERO,
    OVF
  } spc_e;

endpackage

// File: rtl/ysyx_22040632_lzc.sv
// rtl/ysyx_22040632_lzc.sv - parametrised leading-zero counter
// Ports:
//   value  in  WIDTH  - word to scan
//   count  out CNT_W  - number of leading zeros (WIDTH when value is zero)
module ysyx_22040632_lzc #(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] value,
  output logic [CNT_W-1:0] count
);

  // Scanning upward lets the highest set bit make the final assignment.
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) count = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/ysyx_22040632_div_seq.sv
// rtl/ysyx_22040632_div_seq.sv - iterative radix-2 restoring divider with RISC-V semantics
// Optional feature macro: YSYX_22040632_DIV_EARLY_OUT_EN (leading-zero early-out).
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   div_valid/div_ready   - request handshake
//   div_signed, divw      - signed op select, 32-bit word op (ignored when XLEN=32)
//   dividend, divisor     - operands
//   flush                 - abort current operation, discard result
//   out_valid/out_ready   - result handshake
//   quotient, remainder   - registered results
module ysyx_22040632_div_seq
  import ysyx_22040632_div_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            div_valid,
  output logic            div_ready,
  input  logic            div_signed,
  input  logic            divw,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int IDX_W = $clog2(XLEN);

  state_e          state, state_nx;
  logic [XLEN-1:0] a_r, b_r, q_r, rem_r;
  logic [CNT_W-1:0] cnt;
  logic            neg_q, neg_r, w32_r;

  // Narrow results carry bit 31 up to XLEN (RV64 *W behaviour).
  function automatic logic [XLEN-1:0] fit(input logic [XLEN-1:0] x, input logic w32);
    return w32 ? XLEN'($signed(x[31:0])) : x;
  endfunction

  // Accept-time operand conditioning, all confined to the W-bit window.
  logic            w32_in, sign_a, sign_b, accept;
  logic [XLEN-1:0] mask, min_w, a_w, b_w, mag_a, mag_b;
  logic [CNT_W-1:0] w_val, cnt_init;
  spc_e            spc;

  assign w32_in = divw || (XLEN == W32);
  assign mask   = w32_in ? XLEN'({32{1'b1}}) : '1;
  assign min_w  = (mask >> 1) + XLEN'(1);
  assign a_w    = dividend & mask;
  assign b_w    = divisor & mask;
  assign sign_a = div_signed && (w32_in ? dividend[31] : dividend[XLEN-1]);
  assign sign_b = div_signed && (w32_in ? divisor[31] : divisor[XLEN-1]);
  assign mag_a  = sign_a ? ((~a_w + XLEN'(1)) & mask) : a_w;
  assign mag_b  = sign_b ? ((~b_w + XLEN'(1)) & mask) : b_w;
  assign w_val  = w32_in ? CNT_W'(W32) : CNT_W'(XLEN);

  always_comb begin
    spc = NONE;
    if (b_w == '0) spc = DIVZERO;
    else if (div_signed && a_w == min_w && b_w == mask) spc = OVF;
  end

`ifdef YSYX_22040632_DIV_EARLY_OUT_EN
  logic [CNT_W-1:0] lz, lz_w, iters;

  ysyx_22040632_lzc #(.WIDTH(XLEN), .CNT_W(CNT_W)) u_lzc (
    .value(mag_a),
    .count(lz)
  );

  // Upper XLEN-32 bits are always zero in word mode, so lz never underflows here.
  assign lz_w     = w32_in ? lz - CNT_W'(XLEN - W32) : lz;
  assign iters    = w_val - lz_w;
  assign cnt_init = (iters == '0) ? '0 : iters - CNT_W'(1);
`else
  assign cnt_init = w_val - CNT_W'(1);
`endif

  // FSM: next state and handshake outputs.
  always_comb begin
    state_nx  = state;
    div_ready = (state == IDLE) || (state == DONE && out_ready);
    out_valid = (state == DONE);
    accept    = div_valid && div_ready && !flush;
    case (state)
      IDLE: if (accept) state_nx = (spc != NONE) ? DONE : CALC;
      CALC: if (cnt == '0) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: if (out_ready) state_nx = accept ? ((spc != NONE) ? DONE : CALC) : IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // One quotient bit per CALC cycle; dividend bits are consumed by index
  // rather than shifted so that the early-out start point is just a counter load.
  logic [XLEN:0] trial, diff;
  assign trial = {rem_r, a_r[cnt[IDX_W-1:0]]};
  assign diff  = trial - {1'b0, b_r};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r       <= '0;
      b_r       <= '0;
      q_r       <= '0;
      rem_r     <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      w32_r     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (accept) begin
      a_r   <= mag_a;
      b_r   <= mag_b;
      q_r   <= '0;
      rem_r <= '0;
      cnt   <= cnt_init;
      neg_q <= sign_a ^ sign_b;
      neg_r <= sign_a;
      w32_r <= w32_in;
      if (spc == DIVZERO) begin
        quotient  <= '1;
        remainder <= fit(a_w, w32_in);
      end else if (spc == OVF) begin
        quotient  <= fit(a_w, w32_in);
        remainder <= '0;
      end
    end else begin
      case (state)
        CALC: begin
          rem_r                <= diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
          q_r[cnt[IDX_W-1:0]]  <= ~diff[XLEN];
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
        FIX: begin
          quotient  <= fit(neg_q ? -q_r : q_r, w32_r);
          remainder <= fit(neg_r ? -rem_r : rem_r, w32_r);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040632_div_seq.sv
// tb/tb_ysyx_22040632_div_seq.sv - self-checking bench for the sequential divider
module tb_ysyx_22040632_div_seq;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            div_valid, div_ready, div_signed, divw, flush;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] dividend, divisor, quotient, remainder;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q, exp_r;
  int          exp_lat;

  always #5 clk = ~clk;

  ysyx_22040632_div_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .div_valid(div_valid), .div_ready(div_ready),
    .div_signed(div_signed), .divw(divw),
    .dividend(dividend), .divisor(divisor),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference: RISC-V division rules with native arithmetic, plus the expected latency.
  task automatic ref_div(input logic sgn, input logic w, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] q, output logic [63:0] r, output int lat);
    logic [31:0] a32, b32;
    logic [63:0] mag;
    bit          spc;
    int          width, top;
    spc = 0;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      width = 32;
      mag   = (sgn && a32[31]) ? {32'h0, -a32} : {32'h0, a32};
      if (b32 == 0) begin
        q = '1; r = sx(a32); spc = 1;
      end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q = sx(a32); r = 0; spc = 1;
      end else if (sgn) begin
        q = sx($signed(a32) / $signed(b32));
        r = sx($signed(a32) % $signed(b32));
      end else begin
        q = sx(a32 / b32);
        r = sx(a32 % b32);
      end
    end else begin
      width = 64;
      mag   = (sgn && a[63]) ? -a : a;
      if (b == 0) begin
        q = '1; r = a; spc = 1;
      end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q = a; r = 0; spc = 1;
      end else if (sgn) begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end else begin
        q = a / b;
        r = a % b;
      end
    end
    top = 0;
    for (int i = 0; i < width; i++) if (mag[i]) top = i + 1;
`ifdef YSYX_22040632_DIV_EARLY_OUT_EN
    lat = spc ? 1 : ((top < 1) ? 1 : top) + 2;
`else
    lat = spc ? 1 : width + 2;
`endif
  endtask

  // Called at a negedge; returns at the negedge of cycle 1 after the accept.
  task automatic start_op(input logic sgn, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic rdy);
    int k;
    ref_div(sgn, w, a, b, exp_q, exp_r, exp_lat);
    div_signed = sgn;
    divw       = w;
    dividend   = a;
    divisor    = b;
    out_ready  = rdy;
    div_valid  = 1'b1;
    k = 0;
    while (!div_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("accept_ready", div_ready, 1);
    @(posedge clk);
    @(negedge clk);
    div_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int cyc;
    cyc = 1;
    while (!out_valid && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_q"}, quotient, exp_q);
    check({tag, "_r"}, remainder, exp_r);
  endtask

  initial begin
    logic        seen;
    logic [63:0] a, b, fa, hq, hr;
    logic        sgn, w;

    rst = 1'b1; div_valid = 1'b0; div_signed = 1'b0; divw = 1'b0;
    dividend = '0; divisor = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", div_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    rst = 1'b0;
    @(negedge clk);

    start_op(1, 0, -64'sd7, 64'd2, 1);                        wait_result("neg7_div2");
    start_op(0, 1, 64'hFFFF_FFFF, 64'h10, 1);                 wait_result("divuw");
    start_op(1, 0, 64'd5, 64'd0, 1);                          wait_result("divzero");
    start_op(1, 1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1); wait_result("ovf_w");

    // Flush mid-calculation: no result may ever appear.
`ifdef YSYX_22040632_DIV_EARLY_OUT_EN
    fa = 64'h1000_0000_0000_0064;
`else
    fa = 64'd100;
`endif
    @(negedge clk);
    start_op(0, 0, fa, 64'd3, 1);
    seen = 1'b0;
    for (int c = 1; c < 10; c++) begin
      seen |= out_valid;
      @(negedge clk);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_ready", div_ready, 1);
    for (int c = 0; c < 70; c++) begin
      seen |= out_valid;
      @(negedge clk);
    end
    check("flush_no_valid", seen, 0);
    start_op(0, 0, 64'd9, 64'd4, 1); wait_result("after_flush");

    // Flush beats a same-cycle request (a divide-by-zero would be valid next cycle).
    @(negedge clk);
    div_valid = 1'b1; flush = 1'b1; dividend = 64'd5; divisor = 64'd0;
    @(negedge clk);
    div_valid = 1'b0; flush = 1'b0;
    check("flush_prio", out_valid, 0);

    // Backpressure hold, then back-to-back accepts out of DONE.
    start_op(0, 0, 64'd1000, 64'd7, 0); wait_result("bp_first");
    hq = exp_q; hr = exp_r;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_q", quotient, hq);
      check("hold_r", remainder, hr);
    end
    start_op(1, 0, -64'sd77, 64'd5, 1); wait_result("b2b_normal");
    start_op(0, 0, 64'd3, 64'd0, 1);    wait_result("b2b_spc1");
    start_op(1, 1, 64'hDEAD_0000_8000_0000, 64'hFFFF_FFFF, 1); wait_result("b2b_spc2");

    // Reset in the middle of a calculation.
    start_op(0, 0, 64'h1234_5678_9ABC_DEF0, 64'd3, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ready", div_ready, 1);
    check("midrst_valid", out_valid, 0);
    check("midrst_q", quotient, 0);
    check("midrst_r", remainder, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    start_op(0, 0, 64'd1, 64'd1, 1); wait_result("one_by_one");

    for (int n = 0; n < 40; n++) begin
      sgn = 1'($urandom);
      w   = 1'($urandom);
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = 64'($urandom_range(1, 20)) * (((($urandom) & 1) != 0) ? -64'sd1 : 64'sd1);
        2: begin
          a = w ? {a[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000;
          b = w ? {b[63:32], 32'hFFFF_FFFF} : '1;
        end
        3: a = a >> $urandom_range(0, 63);
        4: b = b >> $urandom_range(0, 63);
        default: ;
      endcase
      start_op(sgn, w, a, b, 1);
      wait_result("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
